// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: gates the RO counter,
// averages 2^LOG2_N windows and sends the 16-bit result over UART.
module ro_meas_sequencer #(
    parameter int GATE_CYCLES = 1000,
    parameter int LOG2_N      = 3,
    parameter int SETTLE      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic [15:0] cnt_value,
    input  logic        tx_busy,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        ovf
);

    localparam int AW   = 16 + LOG2_N;
    localparam int NS   = 1 << LOG2_N;
    localparam int SW   = LOG2_N + 1;
    localparam int TMAX = (GATE_CYCLES > SETTLE) ? GATE_CYCLES : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_P = 8'h50;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE_W,
        CAPTURE,
        AVG,
        SEND_LO,
        WAIT_LO,
        SEND_HI,
        WAIT_HI
    } state_t;

    state_t         state;
    logic [AW-1:0]  acc;
    logic [SW-1:0]  smp;
    logic [TW-1:0]  timer;
    logic [15:0]    result;
    logic           cont;
    logic           seen;
    logic           cont_nxt;
    logic           start_cmd;

    // Command decode; a command arriving on a transition cycle still counts.
    always_comb begin
        cont_nxt  = cont;
        start_cmd = 1'b0;
        if (rx_ready) begin
            if (rx_data == CMD_C) cont_nxt = 1'b1;
            if (rx_data == CMD_P) cont_nxt = 1'b0;
            start_cmd = (rx_data == CMD_S) || (rx_data == CMD_C);
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            smp      <= '0;
            timer    <= '0;
            result   <= '0;
            cont     <= 1'b0;
            seen     <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_en   <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            cont     <= cont_nxt;
            cnt_clr  <= 1'b0;
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_cmd) begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                        acc     <= '0;
                        smp     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                CLEAR: begin
                    state  <= GATE;
                    cnt_en <= 1'b1;
                    timer  <= '0;
                end
                GATE: begin
                    if (timer == TW'(GATE_CYCLES - 1)) begin
                        state  <= SETTLE_W;
                        cnt_en <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SETTLE_W: begin
                    if (timer == TW'(SETTLE - 1)) state <= CAPTURE;
                    else timer <= timer + TW'(1);
                end
                CAPTURE: begin
                    acc <= acc + AW'(cnt_value);
                    if (cnt_value == 16'hFFFF) ovf <= 1'b1;
                    if (smp == SW'(NS - 1)) begin
                        state <= AVG;
                    end else begin
                        smp     <= smp + SW'(1);
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                    end
                end
                AVG: begin
                    result <= acc[LOG2_N +: 16];
                    state  <= SEND_LO;
                end
                SEND_LO: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= result[7:0];
                        seen     <= 1'b0;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (tx_busy) seen <= 1'b1;
                    else if (seen) state <= SEND_HI;
                end
                SEND_HI: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= result[15:8];
                        seen     <= 1'b0;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        seen <= 1'b1;
                    end else if (seen) begin
                        if (cont_nxt) begin
                            state   <= CLEAR;
                            cnt_clr <= 1'b1;
                            acc     <= '0;
                            smp     <= '0;
                            ovf     <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Testbench for ro_meas_sequencer with counter and UART models
// and a byte scoreboard.
module tb_ro_meas_sequencer;

    localparam int G  = 10;
    localparam int S  = 2;
    localparam int L2 = 2;
    localparam int LAT = 4 * (G + S + 2) + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] cnt_value = 16'h0;
    logic        tx_busy;
    logic        cnt_clr, cnt_en, tx_start, busy, ovf;
    logic [7:0]  tx_data;

    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;
    int   busy_len = 3;
    int   ub_cnt = 0;

    assign tx_busy = uart_busy | hold_busy;

    ro_meas_sequencer #(
        .GATE_CYCLES(G),
        .LOG2_N(L2),
        .SETTLE(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .cnt_value(cnt_value),
        .tx_busy(tx_busy),
        .cnt_clr(cnt_clr),
        .cnt_en(cnt_en),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_tx = 0;
    int n_clr = 0;
    logic [7:0]  prev_data = 8'h00;
    logic [15:0] samp_q[$];
    logic [7:0]  exp_q[$];
    int          tx_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard, pulse counters and handshake invariants.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (!reset) begin
            prev_data = tx_data;
        end else begin
            if (cnt_clr) n_clr++;
            if (tx_start) begin
                n_tx++;
                tx_cyc.push_back(cyc);
                if (tx_busy) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_start_while_busy: got 1 expected 0");
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_extra: got %0h expected none", tx_data);
                end else begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end else if (tx_data !== prev_data) begin
                n_cmp++;
                n_fail++;
                $display("FAIL tx_data_hold: got %0h expected %0h", tx_data, prev_data);
            end
            prev_data = tx_data;
        end
    end

    // RO counter model: next sample value appears after each clear.
    always @(negedge clk) begin
        if (cnt_clr) cnt_value = (samp_q.size() != 0) ? samp_q.pop_front() : 16'h0;
    end

    // UART model: busy for busy_len cycles after each send strobe.
    always @(negedge clk) begin
        if (ub_cnt > 0) begin
            ub_cnt--;
            if (ub_cnt == 0) uart_busy = 1'b0;
        end
        if (tx_start) begin
            uart_busy = 1'b1;
            ub_cnt = busy_len;
        end
    end

    task automatic send_cmd(input logic [7:0] b, output int c);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data = b;
        c = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string nm);
        int k;
        k = 0;
        while (busy !== lvl && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy !== lvl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got timeout expected busy=%0b", nm, lvl);
        end
    endtask

    task automatic push_result(input logic [15:0] a, b, c, d, r);
        samp_q.push_back(a);
        samp_q.push_back(b);
        samp_q.push_back(c);
        samp_q.push_back(d);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    typedef struct {
        logic [15:0] s0, s1, s2, s3;
        logic [15:0] res;
        logic        ov;
        logic        noise;
    } vec_t;

    vec_t tv[6];

    initial begin
        int c0, tx0, clr0, dummy, r, k;
        tv[0] = '{16'd100, 16'd101, 16'd102, 16'd103, 16'h0065, 1'b0, 1'b0};
        tv[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        tv[2] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'h0005, 1'b0, 1'b1};
        tv[3] = '{16'd3, 16'd0, 16'd0, 16'd0, 16'h0000, 1'b0, 1'b0};
        tv[4] = '{16'd1, 16'd2, 16'd3, 16'd6, 16'h0003, 1'b0, 1'b0};
        tv[5] = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'h3FFF, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_cnt_clr", {31'h0, cnt_clr}, 32'h0);
        chk("rst_cnt_en", {31'h0, cnt_en}, 32'h0);
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            tx0 = n_tx;
            clr0 = n_clr;
            push_result(tv[i].s0, tv[i].s1, tv[i].s2, tv[i].s3, tv[i].res);
            send_cmd(8'h53, c0);
            chk($sformatf("v%0d_ovf_start", i), {31'h0, ovf}, 32'h0);
            chk($sformatf("v%0d_busy_start", i), {31'h0, busy}, 32'h1);
            if (tv[i].noise) begin
                repeat (20) @(negedge clk);
                send_cmd(8'h00, dummy);
                send_cmd(8'h41, dummy);
                send_cmd(8'h53, dummy);
            end
            wait_busy(1'b0, 2000, $sformatf("v%0d_done", i));
            @(negedge clk);
            chk($sformatf("v%0d_ntx", i), n_tx - tx0, 2);
            chk($sformatf("v%0d_nclr", i), n_clr - clr0, 4);
            chk($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, tv[i].ov});
            chk($sformatf("v%0d_expq", i), exp_q.size(), 0);
            if (i == 0 && tx_cyc.size() > tx0)
                chk("latency", tx_cyc[tx0] - c0 - 1, LAT);
            repeat (5) @(negedge clk);
        end

        tx0 = n_tx;
        push_result(16'd7, 16'd7, 16'd7, 16'd7, 16'h0007);
        send_cmd(8'h53, c0);
        hold_busy = 1'b1;
        repeat (LAT + 50) @(negedge clk);
        chk("stall_no_tx", n_tx - tx0, 0);
        hold_busy = 1'b0;
        r = cyc;
        wait_busy(1'b0, 500, "stall_done");
        @(negedge clk);
        chk("stall_ntx", n_tx - tx0, 2);
        if (tx_cyc.size() > tx0)
            chk("stall_release", tx_cyc[tx0] - r, 1);
        chk("stall_expq", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        tx0 = n_tx;
        samp_q.push_back(16'd9);
        send_cmd(8'h53, c0);
        k = 0;
        while (!cnt_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_gate_seen", {31'h0, cnt_en}, 32'h1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_cnt_en", {31'h0, cnt_en}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_tx_start", {31'h0, tx_start}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        samp_q.delete();
        repeat (200) @(negedge clk);
        chk("rst_no_tx", n_tx - tx0, 0);
        chk("rst_idle", {31'h0, busy}, 32'h0);

        busy_len = 20;
        tx0 = n_tx;
        clr0 = n_clr;
        push_result(16'd10, 16'd20, 16'd30, 16'd40, 16'h0019);
        push_result(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h2800);
        push_result(16'hFFFF, 16'd1, 16'd1, 16'd1, 16'h4000);
        send_cmd(8'h43, c0);
        k = 0;
        while (n_clr - clr0 < 9 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("cont_third", n_clr - clr0, 9);
        chk("cont_busy", {31'h0, busy}, 32'h1);
        repeat (5) @(negedge clk);
        send_cmd(8'h50, dummy);
        wait_busy(1'b0, 2000, "cont_done");
        repeat (100) @(negedge clk);
        chk("cont_ntx", n_tx - tx0, 6);
        chk("cont_nclr", n_clr - clr0, 12);
        chk("cont_ovf", {31'h0, ovf}, 32'h1);
        chk("cont_expq", exp_q.size(), 0);
        chk("cont_idle", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_meas_sequencer.md
Name: ro_meas_sequencer

Overview:
Command-driven measurement sequencer for the ring-oscillator temperature sensor.
- Decodes single-byte commands from the UART receiver.
- Opens fixed-length gate windows on the RO edge counter and accumulates 2^LOG2_N window counts.
- Averages the counts and sends the 16-bit result as two UART bytes, LSB first.
- Sits between uart_basic and the contador instance, replacing ad-hoc send-select logic with one scheduler that owns the counter and the transmitter.

Parameters:
- GATE_CYCLES, 1000, clk cycles per gate window (cnt_en high), ≥1.
- LOG2_N, 3, log2 of samples averaged per result (8 samples), range 0..6.
- SETTLE, 2, clk cycles waited after gate close before sampling cnt_value (counter CDC settle), ≥1.

Ports:
- clk  in  1  system clock (muxed internal/external clock).
- reset  in  1  asynchronous, active-low reset.
- rx_ready  in  1  one-cycle strobe: rx_data valid.
- rx_data  in  8  received command byte.
- cnt_value  in  16  RO counter value, stable after SETTLE cycles of cnt_en low.
- tx_busy  in  1  UART transmitter busy.
- cnt_clr  out  1  synchronous clear to RO counter.
- cnt_en  out  1  RO counter gate enable.
- tx_start  out  1  one-cycle UART send strobe.
- tx_data  out  8  byte to send, held stable from tx_start until tx_busy falls.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky: some sample in the current result read 16'hFFFF.

Behaviour:
Reset (reset=0, asynchronous):
- State = IDLE.
- All outputs 0; accumulator, sample count, gate timer and continuous flag cleared.

Commands (sampled only on rx_ready):
- 0x53 'S': in IDLE, start one result.
- 0x43 'C': set continuous flag; in IDLE, also start.
- 0x50 'P': clear continuous flag in any state; the current result still completes and is sent.
- Any other byte: ignored. 'S' while busy: ignored.

State machine (one transition per clk unless noted):
- IDLE: on start → CLEAR. Starting clears the accumulator, the sample count and ovf.
- CLEAR: cnt_clr=1 for exactly 1 cycle → GATE.
- GATE: cnt_en=1 for exactly GATE_CYCLES cycles → SETTLE_W.
- SETTLE_W: cnt_en=0 for SETTLE cycles → CAPTURE.
- CAPTURE (1 cycle):
  - acc += cnt_value; if cnt_value == 16'hFFFF, set ovf.
  - If sample count == 2^LOG2_N−1 → AVG; else increment sample count → CLEAR.
- AVG (1 cycle): result = acc[LOG2_N+15:LOG2_N], i.e. truncating shift, no rounding → SEND_LO.
- SEND_LO: wait for tx_busy=0, then pulse tx_start with tx_data=result[7:0] → WAIT_LO.
- WAIT_LO:
  - Wait for tx_busy=1.
  - Then wait for tx_busy=0.
  - → SEND_HI.
- SEND_HI / WAIT_HI: same handshake with tx_data=result[15:8].
- After WAIT_HI: continuous flag=1 → CLEAR, which starts a fresh result (accumulator, sample count and ovf cleared); continuous flag=0 → IDLE.

Arithmetic and timing:
- Accumulator width is 16+LOG2_N; it never wraps.
- Result latency from the start command to the first tx_start, with tx_busy idle, is 2^LOG2_N·(GATE_CYCLES+SETTLE+2)+2 cycles.

Handshake and boundary rules:
- tx_start is never asserted while tx_busy=1, and is never asserted twice without an intervening busy high→low.
- tx_busy already high on entry to SEND_LO: stall with no pulse.
- rx_ready coincident with a state transition: the command is still decoded in that cycle.
- 'P' and 'C' in the same result: last received wins.
- Reset mid-gate: cnt_en drops immediately (asynchronous), and no partial result is sent.

Test Plan:
- GATE_CYCLES=10, SETTLE=2, LOG2_N=2; model counter returns 100,101,102,103; send 'S' → exactly two tx_start pulses, bytes 0x65 then 0x00; busy falls after second byte; ovf=0.
- Same config, counts 0xFFFF ×4 → bytes 0xFF,0xFF, ovf=1; then 'S' with counts 5,5,5,5 → ovf cleared at start, bytes 0x05,0x00.
- Send 'C', UART model busy 20 cycles per byte → results repeat back-to-back; send 'P' mid-gate of the 3rd result → the 3rd result is fully sent, then IDLE, no 4th CLEAR.
- Hold tx_busy=1 for 50 cycles entering SEND_LO → tx_start stays 0 until the cycle after tx_busy falls; tx_data constant through WAIT_LO.
- Assert reset=0 at GATE cycle 5 → cnt_en, busy, tx_start are 0 in the same cycle; after release, no tx_start without a new command.
- Bytes 0x00, 0x41, 'S' while busy → ignored: cnt_clr count per result = 2^LOG2_N, and exactly 2 tx_start pulses total.
